// File: rtl/sap1_datapath.sv
// SAP-1 datapath: W bus, PC, MAR, 16x8 RAM, IR, A, B, adder/subtractor and output register.
// Optional ALU flags are built only when SAP1_FLAGS_EN is defined.
module sap1_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [11:0]              control_word,
    input  logic                     prog_en,
    input  logic                     prog_we,
    input  logic [ADDR_W-1:0]        prog_addr,
    input  logic [DATA_W-1:0]        prog_data,
    output logic [DATA_W-ADDR_W-1:0] opcode,
    output logic [DATA_W-1:0]        out_data,
    output logic                     halt,
    output logic                     bus_conflict,
    output logic                     carry_flag,
    output logic                     zero_flag
);

    logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
    assign {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo} = control_word;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] bus;
    logic [DATA_W:0]   alu_full;
    logic [DATA_W-1:0] alu_result;
    logic [2:0]        n_drivers;

    // One extra bit holds carry-out on add and borrow on subtract.
    always_comb begin
        if (su) alu_full = {1'b0, a_reg} - {1'b0, b_reg};
        else    alu_full = {1'b0, a_reg} + {1'b0, b_reg};
    end
    assign alu_result = alu_full[DATA_W-1:0];

    always_comb begin
        bus = '0;
        if      (ep) bus = {{(DATA_W-ADDR_W){1'b0}}, pc};
        else if (ce) bus = mem[mar];
        else if (ei) bus = {{(DATA_W-ADDR_W){1'b0}}, ir[ADDR_W-1:0]};
        else if (ea) bus = a_reg;
        else if (eu) bus = alu_result;
    end

    assign n_drivers    = {2'b00, ep} + {2'b00, ce} + {2'b00, ei} + {2'b00, ea} + {2'b00, eu};
    assign bus_conflict = (n_drivers > 3'd1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc       <= '0;
            mar      <= '0;
            ir       <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            out_data <= '0;
        end else if (!prog_en) begin
            if (cp) pc       <= pc + 1'b1;
            if (lm) mar      <= bus[ADDR_W-1:0];
            if (li) ir       <= bus;
            if (la) a_reg    <= bus;
            if (lb) b_reg    <= bus;
            if (lo) out_data <= bus;
        end
    end

    // RAM is deliberately outside reset so a loaded program survives it.
    always_ff @(posedge clock) begin
        if (prog_en && prog_we) mem[prog_addr] <= prog_data;
    end

    assign opcode = ir[DATA_W-1:ADDR_W];
    assign halt   = &opcode;

`ifdef SAP1_FLAGS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
        end else if (!prog_en && la && eu) begin
            carry_flag <= su ? ~alu_full[DATA_W] : alu_full[DATA_W];
            zero_flag  <= (alu_result == '0);
        end
    end
`else
    logic unused_carry;
    assign unused_carry = alu_full[DATA_W];
    assign carry_flag   = 1'b0;
    assign zero_flag    = 1'b0;
`endif

endmodule

// File: doc/sap1_datapath.md
Name: sap1_datapath

Overview:
- SAP-1 datapath directly downstream of the control unit. Consumes its 12-bit active-high control word and feeds the opcode back to it.
- Contains the 8-bit W bus, program counter (PC), memory address register (MAR), 16x8 RAM, instruction register (IR), accumulator (A), B register, adder/subtractor and output register.
- All registers update on the rising clock edge. The control unit advances on the falling edge, so the control word is stable at every rising edge.

Parameters:
- DATA_W, 8, width of bus, RAM words, IR, A, B and output register.
- ADDR_W, 4, width of PC and MAR; RAM depth is 2**ADDR_W; opcode is IR[DATA_W-1:ADDR_W].

Ports:
- clock  input  1  rising-edge register clock
- reset  input  1  reset, asynchronous, active-low
- control_word  input  12  bit11 Cp, 10 Ep, 9 Lm, 8 CE, 7 Li, 6 Ei, 5 La, 4 Ea, 3 Su, 2 Eu, 1 Lb, 0 Lo; all active-high
- prog_en  input  1  program mode: freezes PC, MAR, IR, A, B, OUT and enables RAM write port
- prog_we  input  1  RAM write strobe, honoured only when prog_en=1
- prog_addr  input  ADDR_W  RAM write address
- prog_data  input  DATA_W  RAM write data
- opcode  output  DATA_W-ADDR_W  IR upper field, to control unit
- out_data  output  DATA_W  output register
- halt  output  1  opcode==all-ones (HLT)
- bus_conflict  output  1  more than one bus driver enabled
- carry_flag  output  1  see Optional Feature
- zero_flag  output  1  see Optional Feature

Behaviour:
- Reset (async, low): PC, MAR, IR, A, B and OUT go to 0. Consequences: opcode=0, out_data=0, halt=0, flags=0. RAM contents are not reset.
- Bus (combinational) drive rules:
  - Ep drives zero-extended PC.
  - CE drives RAM[MAR] (asynchronous read).
  - Ei drives zero-extended IR[ADDR_W-1:0].
  - Ea drives A.
  - Eu drives ALU result.
  - No enable: bus=0.
- Bus priority: with multiple enables, priority is Ep>CE>Ei>Ea>Eu and bus_conflict=1 (combinational); otherwise bus_conflict=0.
- ALU: Su=0 gives A+B; Su=1 gives A-B. Result is modulo 2**DATA_W and wraps silently.
- Rising edge with prog_en=0, each action independent and simultaneous:
  - Cp: PC<=PC+1, wrapping 15->0.
  - Lm: MAR<=bus[ADDR_W-1:0].
  - Li: IR<=bus.
  - La: A<=bus.
  - Lb: B<=bus.
  - Lo: OUT<=bus.
- Read-before-write: loads sample the bus value from before the edge. Example: La with Eu loads the old A op B.
- Rising edge with prog_en=1: control_word ignored; all registers hold. If prog_we=1, RAM[prog_addr]<=prog_data.
- prog_we with prog_en=0 is ignored.
- Latency: every load is visible one rising edge after the control word is asserted.
- Reset mid-instruction: registers clear immediately. The next rising edge after release acts on the current control_word.

Optional Feature:
- Macro: SAP1_FLAGS_EN.
- Defined: on a rising edge with La=1 and Eu=1 (prog_en=0), both flags update.
  - carry_flag<=ALU carry-out on add, or no-borrow (A>=B, unsigned) on subtract.
  - zero_flag<=(ALU result==0).
  - Flags otherwise hold; reset clears them.
- Undefined: carry_flag and zero_flag are tied to 0 and no flag logic is built.

Test Plan:
- Reset with registers preloaded via control words -> PC, MAR, IR, A, B and out_data all 0; RAM[3] keeps the value written before reset.
- Program load, then drive the control-unit sequence for LDA 9, ADD A, SUB B, OUT, HLT. Program: RAM[0..4]=09,1A,2B,70,F0; RAM[9,A,B]=10,14,18. Required: A=10, then 24, then 0C; out_data=0C; halt=1 after the HLT fetch; PC=5.
- Sixteen cycles of Cp=1 from PC=F -> PC reads 0 after the first edge (wrap), no other register changes.
- A=05, B=07, control_word 12'h02C -> A=FE. With SAP1_FLAGS_EN: carry=0, zero=0. Then A=07, B=07 subtract -> A=00, carry=1, zero=1.
- control_word with Ep and Ea both set (12'h410), PC=3, A=AA, plus Lo -> bus_conflict=1, out_data=03.
- prog_en=1 with control_word 12'hFFF and prog_we writing RAM[5]=5A -> no register changes; a later CE read of MAR=5 returns 5A.
